// File: rtl/wb_timeout.sv
// rtl/wb_timeout.sv - Wishbone watchdog stage that aborts slave cycles lacking a timely response
module wb_timeout #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = (DATA_WIDTH / 8),
  parameter int TIMEOUT      = 1024,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  input  logic                    wbm_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o,
  output logic                    timeout_o,
  output logic [COUNT_WIDTH-1:0]  timeout_count_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ABORT  = 2'd2;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          slv_resp;
  logic          accept;

  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A strobe still held while the master sees our response is not a new request.
  assign accept   = wbm_cyc_i & wbm_stb_i & ~(wbm_ack_o | wbm_err_o | wbm_rty_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      wbm_dat_o       <= '0;
      wbm_ack_o       <= 1'b0;
      wbm_err_o       <= 1'b0;
      wbm_rty_o       <= 1'b0;
      wbs_adr_o       <= '0;
      wbs_dat_o       <= '0;
      wbs_we_o        <= 1'b0;
      wbs_sel_o       <= '0;
      wbs_stb_o       <= 1'b0;
      wbs_cyc_o       <= 1'b0;
      timeout_o       <= 1'b0;
      timeout_count_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wbm_ack_o <= 1'b0;
          wbm_err_o <= 1'b0;
          wbm_rty_o <= 1'b0;
          timeout_o <= 1'b0;
          wbs_cyc_o <= wbm_cyc_i;
          if (accept) begin
            wbs_adr_o <= wbm_adr_i;
            wbs_dat_o <= wbm_dat_i;
            wbs_we_o  <= wbm_we_i;
            wbs_sel_o <= wbm_sel_i;
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            cnt       <= '0;
            state     <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (slv_resp) begin
            // A response always wins, even in the final counted cycle.
            wbm_dat_o <= wbs_dat_i;
            wbm_ack_o <= wbs_ack_i;
            wbm_err_o <= wbs_err_i;
            wbm_rty_o <= wbs_rty_i;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            wbs_cyc_o <= wbm_cyc_i;
            state     <= ST_IDLE;
          end else if (!wbm_cyc_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            state     <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            wbm_err_o <= 1'b1;
            wbm_dat_o <= '0;
            timeout_o <= 1'b1;
            if (timeout_count_o != {COUNT_WIDTH{1'b1}}) begin
              timeout_count_o <= timeout_count_o + 1'b1;
            end
            state     <= ST_ABORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ABORT: begin
          // Late slave responses land here and are dropped.
          wbm_err_o <= 1'b0;
          timeout_o <= 1'b0;
          wbs_cyc_o <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          wbs_cyc_o <= 1'b0;
          wbs_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_timeout.sv
// tb/tb_wb_timeout.sv - directed and randomized bench for wb_timeout against a transaction-level model
module tb_wb_timeout;

  localparam int TIMEOUT = 16;
  localparam int CNTW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wbm_adr_i = '0, wbm_dat_i = '0, wbm_dat_o;
  logic        wbm_we_i = 1'b0, wbm_stb_i = 1'b0, wbm_cyc_i = 1'b0;
  logic [3:0]  wbm_sel_i = '0;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i = '0;
  logic        wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;
  logic        timeout_o;
  logic [CNTW-1:0] timeout_count_o;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  int stb_rises = 0;
  logic stb_prev = 1'b0;

  wb_timeout #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
    .TIMEOUT(TIMEOUT), .COUNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbm_cyc_i(wbm_cyc_i),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .wbs_cyc_o(wbs_cyc_o),
    .timeout_o(timeout_o), .timeout_count_o(timeout_count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wbs_stb_o === 1'b1 && stb_prev !== 1'b1) stb_rises = stb_rises + 1;
    stb_prev = wbs_stb_o;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dat"}, wbm_dat_o, 0);
    chk({tag, "_resp"}, {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
    chk({tag, "_sadr"}, wbs_adr_o, 0);
    chk({tag, "_sdat"}, wbs_dat_o, 0);
    chk({tag, "_sctl"}, {wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o}, 0);
    chk({tag, "_to"}, {timeout_o, timeout_count_o}, 0);
  endtask

  // One master request; the slave responds on strobe cycle delay+1 (never if delay >= TIMEOUT).
  task automatic txn(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                     input logic [3:0] sel, input int delay, input int rtype,
                     input logic [31:0] rdat, input bit hold, input bit ack_in_abort);
    int  stb_cnt;
    bit  to;
    to = (delay >= TIMEOUT);
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_we_i = we; wbm_sel_i = sel;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    @(negedge clk);
    chk("req_stb", wbs_stb_o, 1);
    chk("req_cyc", wbs_cyc_o, 1);
    chk("req_adr", wbs_adr_o, adr);
    chk("req_dat", wbs_dat_o, dat);
    chk("req_we_sel", {wbs_we_o, wbs_sel_o}, {we, sel});
    stb_cnt = 0;
    while (wbs_stb_o === 1'b1 && stb_cnt < 64) begin
      stb_cnt++;
      if (stb_cnt == delay + 1) begin
        wbs_ack_i = (rtype == 0); wbs_err_i = (rtype == 1); wbs_rty_i = (rtype == 2);
        wbs_dat_i = rdat;
      end else begin
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
        wbs_dat_i = $urandom;
      end
      @(negedge clk);
    end
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    chk("stb_cycles", stb_cnt, to ? TIMEOUT : delay + 1);
    if (to) begin
      if (model_cnt < (1 << CNTW) - 1) model_cnt++;
      chk("to_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b010);
      chk("to_dat", wbm_dat_o, 0);
      chk("to_pulse", timeout_o, 1);
      chk("to_abort_cyc", wbs_cyc_o, 0);
    end else begin
      chk("resp", {wbm_ack_o, wbm_err_o, wbm_rty_o},
          {rtype == 0, rtype == 1, rtype == 2});
      chk("resp_dat", wbm_dat_o, rdat);
      chk("resp_no_to", timeout_o, 0);
      chk("resp_we", wbs_we_o, 0);
    end
    chk("to_count", timeout_count_o, model_cnt);
    if (to && ack_in_abort) begin
      wbs_ack_i = 1'b1; wbs_dat_i = 32'hBAD0BAD0;
    end
    if (!hold) begin
      wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    end
    @(negedge clk);
    wbs_ack_i = 1'b0;
    chk("resp_one_cycle", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 0);
    chk("no_dup_stb", wbs_stb_o, 0);
    if (!hold) chk("idle_cyc", wbs_cyc_o, 0);
  endtask

  initial begin
    int r0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    txn(32'h1000, 32'h0, 1'b0, 4'hF, 2, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    txn(32'h20, 32'h12345678, 1'b1, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0);
    txn(32'h40, 32'h0, 1'b0, 4'hF, 1000, 0, 32'h0, 1'b0, 1'b0);
    txn(32'h44, 32'h0, 1'b0, 4'h3, TIMEOUT - 1, 0, 32'hCAFEF00D, 1'b0, 1'b0);
    txn(32'h48, 32'h0, 1'b0, 4'hF, 1000, 0, 32'h0, 1'b0, 1'b1);

    r0 = stb_rises;
    txn(32'h100, 32'h0, 1'b0, 4'hF, 1, 0, 32'h11111111, 1'b1, 1'b0);
    txn(32'h104, 32'h0, 1'b0, 4'hF, 0, 0, 32'h22222222, 1'b1, 1'b0);
    txn(32'h108, 32'h0, 1'b0, 4'hF, 3, 0, 32'h33333333, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("b2b_strobes", stb_rises - r0, 3);

    // Master abandons the cycle after five strobe cycles.
    wbm_adr_i = 32'h200; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("mabort_active", wbs_stb_o, 1);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge clk);
    chk("mabort_ctl", {wbs_cyc_o, wbs_stb_o}, 0);
    chk("mabort_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 0);
    @(negedge clk);
    chk("mabort_resp2", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 0);

    for (int i = 0; i < 12; i++) begin
      txn($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom_range(0, TIMEOUT + 3), $urandom_range(0, 2), $urandom, 1'b0, 1'b0);
    end
    repeat (3) txn(32'h300, 32'h0, 1'b0, 4'hF, 1000, 0, 32'h0, 1'b0, 1'b0);
    chk("saturated", timeout_count_o, 3);

    wbm_adr_i = 32'h400; wbm_dat_i = 32'h55; wbm_we_i = 1'b1;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_active", wbs_stb_o, 1);
    rst = 1'b1;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge clk);
    model_cnt = 0;
    chk_all_zero("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    txn(32'h500, 32'h0, 1'b0, 4'hF, 4, 2, 32'h0BADF00D, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
